// File: rtl/alu_seq_n_bits_if.sv
// Request/response bundle between decode, the sequential ALU and writeback.
// Master drives the operation and consumes the result. Slave is the ALU.
// Pure wiring; no logic lives here.
interface alu_seq_n_bits_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    modport master (
        output in_valid, a, b, alu_control, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, alu_control, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/alu_seq_n_bits.sv
// Handshaked ALU with a registered result and NZCV flags. MUL uses an iterative shift-add unit.
// Latency: 1 cycle for non-MUL ops. MUL takes WIDTH+1 cycles. One operation is in flight at a time.
// Backpressure: the result is held while out_ready is low. in_ready follows out_ready in DONE.
module alu_seq_n_bits #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    alu_seq_n_bits_if.slave     bus
);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_ORR = 4'b0011;
    localparam logic [3:0] OP_EOR = 4'b0100;
    localparam logic [3:0] OP_LSL = 4'b0101;
    localparam logic [3:0] OP_LSR = 4'b0110;
    localparam logic [3:0] OP_ASR = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_RSB = 4'b1001;
    localparam logic [3:0] OP_MOV = 4'b1010;
    localparam logic [3:0] OP_MVN = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [3:0]           flags_q, flags_d;
    logic [2*WIDTH-1:0]   mul_acc_q, mul_acc_d;
    logic [2*WIDTH-1:0]   mul_mcand_q, mul_mcand_d;
    logic [WIDTH-1:0]     mul_mplier_q, mul_mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 accept;
    logic [WIDTH-1:0]     add_x, add_y;
    logic                 add_cin;
    logic [WIDTH:0]       add_sum;
    logic                 sh_big;
    logic [SHW-1:0]       sh_amt;
    logic [WIDTH:0]       lsl_ext, lsr_ext, asr_ext;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c, alu_v;
    logic [3:0]           alu_flags;
    logic [2*WIDTH-1:0]   step_acc;
    logic [WIDTH-1:0]     mul_res;
    logic [3:0]           mul_flags;

    assign bus.in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign accept        = bus.in_valid && bus.in_ready;

    // Shared adder: SUB is a+~b+1, RSB is b+~a+1, so C=1 means no borrow.
    always_comb begin
        add_x   = bus.a;
        add_y   = bus.b;
        add_cin = 1'b0;
        if (bus.alu_control == OP_SUB) begin
            add_y   = ~bus.b;
            add_cin = 1'b1;
        end else if (bus.alu_control == OP_RSB) begin
            add_x   = bus.b;
            add_y   = ~bus.a;
            add_cin = 1'b1;
        end
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    end

    // Shifts run on a one-bit-wider vector so the last bit shifted out lands in the spare bit.
    always_comb begin
        sh_big  = (bus.b >= WIDTH_V);
        sh_amt  = bus.b[SHW-1:0];
        lsl_ext = {1'b0, bus.a} << sh_amt;
        lsr_ext = {bus.a, 1'b0} >> sh_amt;
        asr_ext = $signed({bus.a, 1'b0}) >>> sh_amt;
    end

    // Single-cycle datapath for every opcode except MUL.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.alu_control)
            OP_ADD, OP_SUB, OP_RSB: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != add_x[WIDTH-1]);
            end
            OP_AND: alu_res = bus.a & bus.b;
            OP_ORR: alu_res = bus.a | bus.b;
            OP_EOR: alu_res = bus.a ^ bus.b;
            OP_MOV: alu_res = bus.b;
            OP_MVN: alu_res = ~bus.b;
            OP_LSL: begin
                if (!sh_big) begin
                    alu_res = lsl_ext[WIDTH-1:0];
                    alu_c   = lsl_ext[WIDTH];
                end
            end
            OP_LSR: begin
                if (!sh_big) begin
                    alu_res = lsr_ext[WIDTH:1];
                    alu_c   = lsr_ext[0];
                end
            end
            OP_ASR: begin
                if (sh_big) begin
                    alu_res = {WIDTH{bus.a[WIDTH-1]}};
                    alu_c   = bus.a[WIDTH-1];
                end else begin
                    alu_res = asr_ext[WIDTH:1];
                    alu_c   = asr_ext[0];
                end
            end
            default: alu_res = '0;
        endcase
        alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
    end

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        step_acc  = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);
        mul_res   = step_acc[WIDTH-1:0];
        mul_flags = {mul_res[WIDTH-1], (mul_res == '0), 1'b0, |step_acc[2*WIDTH-1:WIDTH]};
    end

    // Next-state logic: accept in IDLE or DONE, iterate in BUSY, hold in DONE until consumed.
    always_comb begin
        state_d      = state_q;
        result_d     = result_q;
        flags_d      = flags_q;
        mul_acc_d    = mul_acc_q;
        mul_mcand_d  = mul_mcand_q;
        mul_mplier_d = mul_mplier_q;
        cnt_d        = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (bus.alu_control == OP_MUL) begin
                        mul_acc_d    = '0;
                        mul_mcand_d  = {{WIDTH{1'b0}}, bus.a};
                        mul_mplier_d = bus.b;
                        cnt_d        = '0;
                        state_d      = S_BUSY;
                    end else begin
                        result_d = alu_res;
                        flags_d  = alu_flags;
                        state_d  = S_DONE;
                    end
                end else if (state_q == S_DONE && bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                mul_acc_d    = step_acc;
                mul_mcand_d  = mul_mcand_q << 1;
                mul_mplier_d = mul_mplier_q >> 1;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = mul_res;
                    flags_d  = mul_flags;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers. Reset aborts any in-flight operation and clears the visible result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            result_q     <= '0;
            flags_q      <= '0;
            mul_acc_q    <= '0;
            mul_mcand_q  <= '0;
            mul_mplier_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            mul_acc_q    <= mul_acc_d;
            mul_mcand_q  <= mul_mcand_d;
            mul_mplier_q <= mul_mplier_d;
            cnt_q        <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_seq_n_bits.sv
// Self-checking bench for alu_seq_n_bits at WIDTH=4.
// Directed vectors plus randomized ops checked against an arithmetic reference model.
// Covers backpressure and reset-abort of a multiply.
module tb_alu_seq_n_bits;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    alu_seq_n_bits_if #(.WIDTH(W)) bus ();
    alu_seq_n_bits #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Reference model built from the opcode rules, using plain integer arithmetic.
    function automatic void model(input int a, input int b, input int op,
                                  output int r, output int f);
        int mask, half, sa, sb, s, c, v, n, z;
        mask = (1 << W) - 1;
        half = 1 << (W - 1);
        sa = (a >= half) ? a - (1 << W) : a;
        sb = (b >= half) ? b - (1 << W) : b;
        r = 0; c = 0; v = 0;
        case (op)
            0: begin s = a + b; r = s & mask; c = (s >> W) & 1;
                     v = (sa + sb > half - 1 || sa + sb < -half) ? 1 : 0; end
            1: begin s = a + ((~b) & mask) + 1; r = s & mask; c = (s >> W) & 1;
                     v = (sa - sb > half - 1 || sa - sb < -half) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: if (b == 0) r = a;
               else if (b < W) begin r = (a << b) & mask; c = (a >> (W - b)) & 1; end
            6: if (b == 0) r = a;
               else if (b < W) begin r = a >> b; c = (a >> (b - 1)) & 1; end
            7: if (b == 0) r = a;
               else if (b < W) begin r = (sa >>> b) & mask; c = (a >> (b - 1)) & 1; end
               else begin r = (sa < 0) ? mask : 0; c = (sa < 0) ? 1 : 0; end
            8: begin s = a * b; r = s & mask; v = ((s >> W) != 0) ? 1 : 0; end
            9: begin s = b + ((~a) & mask) + 1; r = s & mask; c = (s >> W) & 1;
                     v = (sb - sa > half - 1 || sb - sa < -half) ? 1 : 0; end
            10: r = b;
            11: r = (~b) & mask;
            default: r = 0;
        endcase
        n = (r >> (W - 1)) & 1;
        z = (r == 0) ? 1 : 0;
        f = n * 8 + z * 4 + c * 2 + v;
    endfunction

    // Issue one operation, scramble inputs after accept, wait (bounded) for out_valid.
    task automatic do_op(input int a, input int b, input int op,
                         output int r, output int f, output int lat, output bit rdy_busy);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        bus.a           = a[W-1:0];
        bus.b           = b[W-1:0];
        bus.alu_control = op[3:0];
        bus.in_valid    = 1'b1;
        @(posedge clk); #1;
        bus.in_valid    = 1'b0;
        bus.a           = W'($urandom);
        bus.b           = W'($urandom);
        bus.alu_control = 4'($urandom);
        lat = 0;
        rdy_busy = 1'b0;
        while (!bus.out_valid && lat < 3 * W + 10) begin
            if (bus.in_ready) rdy_busy = 1'b1;
            @(posedge clk); #1; lat++;
        end
        r = int'(bus.result);
        f = int'(bus.flags);
    endtask

    task automatic test_reset();
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.result !== 4'b0000) $display("FAIL reset_result got=%b want=0000", bus.result); else n_pass++;
        n_checks++; if (bus.flags !== 4'b0000) $display("FAIL reset_flags got=%b want=0000", bus.flags); else n_pass++;
    endtask

    task automatic test_directed();
        // a, b, op, expected result, expected flags, expected latency
        int vec[8][6] = '{
            '{7, 1, 0,  8, 'b1001, 0},
            '{8, 8, 0,  0, 'b0111, 0},
            '{9, 1, 6,  4, 'b0010, 0},
            '{8, 5, 7, 15, 'b1010, 0},
            '{3, 0, 5,  3, 'b0000, 0},
            '{3, 5, 8, 15, 'b1000, 4},
            '{7, 3, 8,  5, 'b0001, 4},
            '{2, 3, 14, 0, 'b0100, 0}
        };
        int r, f, lat;
        bit rb;
        for (int i = 0; i < 8; i++) begin
            do_op(vec[i][0], vec[i][1], vec[i][2], r, f, lat, rb);
            n_checks++; if (r != vec[i][3]) $display("FAIL dir%0d_result got=%0d want=%0d", i, r, vec[i][3]); else n_pass++;
            n_checks++; if (f != vec[i][4]) $display("FAIL dir%0d_flags got=%b want=%b", i, f[3:0], vec[i][4]); else n_pass++;
            n_checks++; if (lat != vec[i][5]) $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, vec[i][5]); else n_pass++;
            if (vec[i][2] == 8) begin
                n_checks++; if (rb !== 1'b0) $display("FAIL dir%0d_busy_in_ready got=%b want=0", i, rb); else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int r, f, lat;
        bit rb;
        do_op(7, 3, 1, r, f, lat, rb);
        n_checks++; if (r != 4 || f != 'b0010) $display("FAIL b2b_first got=%0d/%b want=4/0010", r, f[3:0]); else n_pass++;
        n_checks++; if (lat != 0) $display("FAIL b2b_first_latency got=%0d want=0", lat); else n_pass++;
        do_op(0, 3, 1, r, f, lat, rb);
        n_checks++; if (r != 13 || f != 'b1000) $display("FAIL b2b_second got=%0d/%b want=13/1000", r, f[3:0]); else n_pass++;
        n_checks++; if (lat != 0) $display("FAIL b2b_second_latency got=%0d want=0", lat); else n_pass++;
    endtask

    task automatic test_backpressure();
        int r, f, lat;
        bit rb;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        do_op(5, 9, 14, r, f, lat, rb);
        n_checks++; if (r != 0 || f != 'b0100) $display("FAIL illegal_op got=%0d/%b want=0/0100", r, f[3:0]); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.result !== 4'b0000 || bus.flags !== 4'b0100 || bus.in_ready !== 1'b0)
                $display("FAIL hold%0d got ov=%b res=%b fl=%b rdy=%b want ov=1 res=0000 fl=0100 rdy=0",
                         i, bus.out_valid, bus.result, bus.flags, bus.in_ready);
            else n_pass++;
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready got=%b want=1", bus.in_ready); else n_pass++;
        do_op(1, 1, 0, r, f, lat, rb);
        n_checks++; if (r != 2 || f != 0 || lat != 0) $display("FAIL release_add got=%0d/%b lat=%0d want=2/0000 lat=0", r, f[3:0], lat); else n_pass++;
    endtask

    task automatic test_reset_mid_mul();
        int r, f, lat;
        bit rb;
        @(posedge clk); #1;
        bus.a = 4'b0011; bus.b = 4'b0101; bus.alu_control = 4'b1000; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL mid_mul_out_valid got=%b want=0", bus.out_valid); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 4'b0000 || bus.flags !== 4'b0000)
            $display("FAIL post_reset got ov=%b rdy=%b res=%b fl=%b want ov=0 rdy=1 res=0000 fl=0000",
                     bus.out_valid, bus.in_ready, bus.result, bus.flags);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL aborted_mul_pulse%0d got=%b want=0", i, bus.out_valid); else n_pass++;
        end
        do_op(0, 10, 10, r, f, lat, rb);
        n_checks++; if (r != 10 || f != 'b1000) $display("FAIL mov_after_reset got=%0d/%b want=10/1000", r, f[3:0]); else n_pass++;
    endtask

    task automatic test_random();
        int a, b, op, r, f, lat, er, ef;
        bit rb;
        for (int i = 0; i < 150; i++) begin
            a  = int'($urandom_range(0, 15));
            b  = int'($urandom_range(0, 15));
            op = int'($urandom_range(0, 15));
            model(a, b, op, er, ef);
            do_op(a, b, op, r, f, lat, rb);
            n_checks++;
            if (r != er || f != ef)
                $display("FAIL rand%0d op=%0d a=%0d b=%0d got=%0d/%b want=%0d/%b", i, op, a, b, r, f[3:0], er, ef[3:0]);
            else n_pass++;
            n_checks++;
            if (lat != ((op == 8) ? W : 0))
                $display("FAIL rand%0d_latency op=%0d got=%0d want=%0d", i, op, lat, (op == 8) ? W : 0);
            else n_pass++;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b1;
        bus.a           = '0;
        bus.b           = '0;
        bus.alu_control = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_mul();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_seq_n_bits.md
# alu_seq_n_bits

Parametrised, handshaked sequential ALU: next generation of the combinational `ALU_N_bits`, adding an iterative shift-add multiplier, shifts with carry-out and valid/ready flow control. It sits between the decode stage and register writeback. It holds one operation in flight and returns a registered result plus NZCV flags.

## Interface

Parameters:
- `WIDTH`, default 32: operand/result width; legal range 4..64.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high.
- `in_valid`: input, 1 bit. Operation request.
- `in_ready`: output, 1 bit. Block can accept a request this cycle.
- `a`: input, WIDTH bits. Operand A.
- `b`: input, WIDTH bits. Operand B; also the shift amount for shifts.
- `alu_control`: input, 4 bits. Opcode.
- `out_valid`: output, 1 bit. `result`/`flags` are valid.
- `out_ready`: input, 1 bit. Consumer takes the result this cycle.
- `result`: output, WIDTH bits. Registered result.
- `flags`: output, 4 bits. Registered {N,Z,C,V}.

## Operation

- Opcodes:
  - 0000 ADD a+b.
  - 0001 SUB a-b, computed as a+~b+1.
  - 0010 AND.
  - 0011 ORR.
  - 0100 EOR.
  - 0101 LSL a<<b.
  - 0110 LSR a>>b.
  - 0111 ASR a>>>b.
  - 1000 MUL, low WIDTH bits of unsigned a*b.
  - 1001 RSB b-a.
  - 1010 MOV b.
  - 1011 MVN ~b.
  - 1100..1111 illegal: result 0, flags 0100.
- Flag rules:
  - N = result[WIDTH-1]; Z = (result==0).
  - ADD/SUB/RSB: C = carry out of the WIDTH-bit adder (SUB C=1 means no borrow); V = signed overflow.
  - AND/ORR/EOR/MOV/MVN: C=0, V=0.
  - Shifts: amount = unsigned b.
    - Amount 0: result = a, C=0.
    - Amount 1..WIDTH-1: C = last bit shifted out.
    - Amount >= WIDTH: LSL/LSR give 0 with C=0; ASR gives all copies of a[WIDTH-1] with C = a[WIDTH-1].
    - V=0 for all shifts.
  - MUL: C=0; V=1 iff the full 2*WIDTH-bit unsigned product has any nonzero bit above WIDTH-1.
- FSM states:
  - IDLE: in_ready=1. On accept (in_valid&&in_ready):
    - non-MUL op: compute, register result/flags, go to DONE.
    - MUL: latch operands, clear accumulator, counter=0, go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle does one shift-add step (examines one bit of b, LSB first) and counter+1. After WIDTH steps: register result/flags, go to DONE.
  - DONE: out_valid=1. result/flags held stable until out_ready=1.
    - On out_ready with no new accept: go to IDLE.
    - in_ready = out_ready, so a new op may be accepted in the same cycle the result is consumed. That op follows the IDLE rules.
- Inputs are sampled only on the accept edge; changes to a/b/alu_control afterwards have no effect.
- reset has priority over everything. Reset in any state (including mid-MUL) aborts the operation, and no out_valid pulse is produced for it.

## Timing

- Reset values: state IDLE, in_ready=1 (in the cycle after reset), out_valid=0, result=0, flags=0000, counter=0.
- Non-MUL latency: accept on edge e0; out_valid=1 in the cycle after e0.
- MUL latency: accept on e0; BUSY steps on e1..eWIDTH; out_valid=1 in the cycle after eWIDTH.
- Throughput:
  - Back-to-back non-MUL ops with out_ready held 1: one result per cycle.
  - MUL: one result per WIDTH+1 cycles.
- Backpressure: while out_valid && !out_ready, result, flags, out_valid and in_ready=0 are held. No input is lost.
- `flags` changes only when a new result is registered.

## Test plan

All scenarios use WIDTH=4.
- SUB back-to-back, out_ready=1:
  - a=0111, b=0011 -> result 0100, flags 0010 (C=1).
  - Then a=0000, b=0011 -> result 1101, flags 1000.
  - Each result appears one cycle after its accept; out_valid stays 1 across the two results.
- ADD overflow and zero:
  - 0111+0001 -> 1000, flags 1001.
  - 1000+1000 -> 0000, flags 0111.
- Shifts:
  - LSR 1001 by 1 -> 0100, C=1.
  - ASR 1000 by 5 -> 1111, flags 1010.
  - LSL 0011 by 0 -> 0011, C=0.
- MUL:
  - 0011*0101 -> 1111, flags 1000; out_valid rises 4 edges after the accept edge, and in_ready=0 throughout BUSY.
  - 0111*0011 -> 0101, V=1.
- Backpressure and illegal opcode:
  - Illegal opcode 1110 -> result 0000, flags 0100.
  - Hold out_ready=0 for 3 cycles: result, flags and out_valid stay stable, in_ready=0.
  - Then raise out_ready with in_valid=1 (ADD 0001+0001): accepted the same cycle, 0010 valid in the next cycle.
- Reset mid-MUL: assert reset after 2 BUSY steps -> out_valid stays 0, the next cycle shows IDLE with in_ready=1, result=0000 and flags=0000. A subsequent MOV b=1010 returns 1010, flags 1000.
